avst_packet_source: RTL and testbench

- Avalon-ST source that generates framed test packets from a command and drives them into an Avalon-ST sink, such as the team's Avalon FIFO write side.
- It honours the sink's ready latency.
- Each packet is a deterministic incrementing byte pattern, so a downstream checker can verify it.
- It is the transmitter counterpart to the FIFO and stream-sink blocks, and the stimulus end of FIFO test rigs.

---
 rtl/avst_pkg.sv | 21 ++
 rtl/avst_packet_source_if.sv | 23 ++
 rtl/ready_delay_line.sv | 36 +++
 rtl/avst_packet_source.sv | 146 ++++++++++++++
 tb/tb_avst_packet_source.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/avst_pkg.sv
// Shared types and helpers for the Avalon-ST packet source.
// Pure declarations: no latency, no backpressure.
package avst_pkg;

    localparam int MAX_READY_LATENCY = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    // A one-symbol or two-symbol beat still needs a 1-bit empty field.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/avst_packet_source_if.sv
// Avalon-ST source bundle; master drives beats, slave returns ready.
// Wiring only: no latency; ready semantics depend on the sink's ready latency.
interface avst_packet_source_if #(
    parameter int WIDTH   = 32,
    parameter int EMPTY_W = 2
);
    logic               src_valid;
    logic [WIDTH-1:0]   src_data;
    logic               src_sop;
    logic               src_eop;
    logic [EMPTY_W-1:0] src_empty;
    logic               src_ready;

    modport master (
        output src_valid, src_data, src_sop, src_eop, src_empty,
        input  src_ready
    );

    modport slave (
        input  src_valid, src_data, src_sop, src_eop, src_empty,
        output src_ready
    );
endinterface

// File: rtl/ready_delay_line.sv
// Delays the sink ready by N cycles to form the ready qualifier; N=0 passes through.
// Latency N cycles; no backpressure of its own, cleared by reset.
module ready_delay_line #(
    parameter int N = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic src_ready,
    output logic rdy_q
);

    if (N == 0) begin : g_pass
        logic sink_unused;
        assign sink_unused = &{1'b0, clk, rst};
        assign rdy_q       = src_ready;
    end else begin : g_pipe
        logic [N-1:0] pipe_q;
        logic [N-1:0] pipe_d;

        always_comb begin
            pipe_d    = pipe_q << 1;
            pipe_d[0] = src_ready;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign rdy_q = pipe_q[N-1];
    end

endmodule

// File: rtl/avst_packet_source.sv
// Generates framed incrementing-byte packets from a command onto an Avalon-ST source.
// First beat one cycle after command accept; stalls on ready (RL=0) or only drives valid when delayed ready allows (RL>0).
module avst_packet_source
    import avst_pkg::*;
#(
    parameter int DATABITS_PER_SYMBOL = 8,
    parameter int SYMBOLS_PER_BEAT    = 4,
    parameter int WIDTH               = SYMBOLS_PER_BEAT * DATABITS_PER_SYMBOL,
    parameter int EMPTY_W             = clog2_min1(SYMBOLS_PER_BEAT),
    parameter int LEN_W               = 16,
    parameter int READY_LATENCY       = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [LEN_W-1:0]               cmd_len,
    input  logic [DATABITS_PER_SYMBOL-1:0] cmd_seed,
    avst_packet_source_if.master           src,
    output logic                           busy,
    output logic                           pkt_done,
    output logic                           len_err
);

    localparam int LW1   = LEN_W + 1;
    localparam int DLY_N = (READY_LATENCY > MAX_READY_LATENCY) ? MAX_READY_LATENCY : READY_LATENCY;

    state_t                         state_q, state_d;
    logic [LEN_W-1:0]               len_q, len_d;
    logic [LEN_W-1:0]               beats_q, beats_d;
    logic [LEN_W-1:0]               idx_q, idx_d;
    logic [DATABITS_PER_SYMBOL-1:0] seed_q, seed_d;
    logic                           pkt_done_q, pkt_done_d;
    logic                           len_err_q, len_err_d;

    logic                           rdy_q;
    logic                           xfer;
    logic                           last_beat;
    logic [LW1-1:0]                 base_sym;
    logic [WIDTH-1:0]               beat_dat;
    logic [EMPTY_W-1:0]             empty_dat;

    ready_delay_line #(
        .N (DLY_N)
    ) u_ready_delay_line (
        .clk       (clk),
        .rst       (rst),
        .src_ready (src.src_ready),
        .rdy_q     (rdy_q)
    );

    // With RL=0 rdy_q is the live ready; with RL>0 every valid beat is a transfer.
    assign xfer      = (state_q == SEND) && rdy_q;
    assign last_beat = (idx_q == beats_q - LEN_W'(1));
    assign empty_dat = EMPTY_W'(LW1'(beats_q) * LW1'(SYMBOLS_PER_BEAT) - {1'b0, len_q});

    // Symbol j of the current beat; positions past the packet length read as zero.
    always_comb begin
        beat_dat = '0;
        base_sym = {1'b0, idx_q} * LW1'(SYMBOLS_PER_BEAT);
        for (int j = 0; j < SYMBOLS_PER_BEAT; j++) begin
            if ((base_sym + LW1'(j)) < {1'b0, len_q}) begin
                beat_dat[WIDTH-1-j*DATABITS_PER_SYMBOL -: DATABITS_PER_SYMBOL] =
                    seed_q + DATABITS_PER_SYMBOL'(base_sym) + DATABITS_PER_SYMBOL'(j);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        seed_d     = seed_q;
        beats_d    = beats_q;
        idx_d      = idx_q;
        pkt_done_d = 1'b0;
        len_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        len_d   = cmd_len;
                        seed_d  = cmd_seed;
                        beats_d = LEN_W'(ceil_div(32'(cmd_len), SYMBOLS_PER_BEAT));
                        idx_d   = '0;
                        state_d = SEND;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    idx_d = idx_q + LEN_W'(1);
                    if (last_beat) begin
                        state_d    = IDLE;
                        pkt_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            seed_q     <= '0;
            beats_q    <= '0;
            idx_q      <= '0;
            pkt_done_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            seed_q     <= seed_d;
            beats_q    <= beats_d;
            idx_q      <= idx_d;
            pkt_done_q <= pkt_done_d;
            len_err_q  <= len_err_d;
        end
    end

    always_comb begin
        src.src_valid = 1'b0;
        src.src_data  = '0;
        src.src_sop   = 1'b0;
        src.src_eop   = 1'b0;
        src.src_empty = '0;
        if (state_q == SEND) begin
            src.src_valid = (READY_LATENCY == 0) ? 1'b1 : rdy_q;
            src.src_data  = beat_dat;
            src.src_sop   = (idx_q == '0);
            src.src_eop   = last_beat;
            if (last_beat) begin
                src.src_empty = empty_dat;
            end
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == SEND);
    assign pkt_done  = pkt_done_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_avst_packet_source.sv
// Scoreboard bench: one DUT at ready latency 0 and one at ready latency 2, driven by the same command sequence.
module tb_avst_packet_source;

    localparam int SPB = 4;

    typedef struct packed {
        logic [31:0] dat;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    typedef struct packed {
        logic  gap;
        beat_t b;
    } exp_t;

    logic clk;
    int   cyc;
    int   total;
    int   bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int rl, input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL rl%0d %s: got 0x%0h, want 0x%0h (cycle %0d)", rl, name, act, want, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_rl
        localparam int RL = 2 * g;

        logic        rst;
        logic        cmd_valid;
        logic        cmd_ready;
        logic [15:0] cmd_len;
        logic [7:0]  cmd_seed;
        logic        busy;
        logic        pkt_done;
        logic        len_err;
        bit          done;
        bit          rnd_rdy;
        bit          rdy_pat[$];
        bit          hist[$];
        exp_t        exp_q[$];
        bit          held_vld;
        beat_t       held;
        int          pkt_due = -10;
        int          len_err_due = -10;
        int          last_eop_cyc = -10;

        avst_packet_source_if #(.WIDTH(32), .EMPTY_W(2)) sif ();

        avst_packet_source #(
            .DATABITS_PER_SYMBOL (8),
            .SYMBOLS_PER_BEAT    (SPB),
            .WIDTH               (32),
            .EMPTY_W             (2),
            .LEN_W               (16),
            .READY_LATENCY       (RL)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid),
            .cmd_ready (cmd_ready),
            .cmd_len   (cmd_len),
            .cmd_seed  (cmd_seed),
            .src       (sif),
            .busy      (busy),
            .pkt_done  (pkt_done),
            .len_err   (len_err)
        );

        // Reference: packet is the byte stream seed, seed+1, ... cut into SPB-symbol beats, MSB first.
        task automatic push_model(input int len, input int seed, input bit gap);
            int nb;
            nb = (len + SPB - 1) / SPB;
            for (int b = 0; b < nb; b++) begin
                exp_t e;
                e.gap     = gap && (b == 0);
                e.b.dat   = '0;
                for (int j = 0; j < SPB; j++) begin
                    int k;
                    k       = b * SPB + j;
                    e.b.dat = e.b.dat << 8;
                    if (k < len) e.b.dat[7:0] = 8'((seed + k) % 256);
                end
                e.b.sop   = (b == 0);
                e.b.eop   = (b == nb - 1);
                e.b.empty = (b == nb - 1) ? 2'(nb * SPB - len) : 2'd0;
                exp_q.push_back(e);
            end
        endtask

        task automatic send_cmd(input int len, input int seed, input bit gap);
            int n;
            n = 0;
            @(posedge clk); #1;
            cmd_len   = 16'(len);
            cmd_seed  = 8'(seed);
            cmd_valid = 1'b1;
            do begin
                @(negedge clk);
                n++;
            end while (!cmd_ready && n < 40000);
            if (!cmd_ready) begin
                total++;
                bad++;
                $display("FAIL rl%0d cmd_timeout: cmd_ready stayed 0, want 1", RL);
            end else begin
                push_model(len, seed, gap);
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            if (len == 0) len_err_due = cyc;
        endtask

        task automatic wait_done();
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while ((exp_q.size() != 0 || busy) && n < 70000);
            if (n >= 70000) begin
                total++;
                bad++;
                $display("FAIL rl%0d drain_timeout: %0d beats outstanding, want 0", RL, exp_q.size());
            end
            @(negedge clk);
        endtask

        initial begin : p_ready
            sif.src_ready = 1'b1;
            forever begin
                @(posedge clk); #1;
                if (rdy_pat.size() != 0) sif.src_ready = rdy_pat.pop_front();
                else if (rnd_rdy)        sif.src_ready = ($urandom_range(0, 3) != 0);
                else                     sif.src_ready = 1'b1;
            end
        end

        always @(negedge clk) begin : p_mon
            beat_t cur;
            exp_t  want;
            logic  dly;
            cur = '{dat: sif.src_data, sop: sif.src_sop, eop: sif.src_eop, empty: sif.src_empty};
            if (RL == 0) dly = sif.src_ready;
            else         dly = (hist.size() >= RL) ? hist[hist.size() - RL] : 1'b0;
            if (rst) begin
                hist.delete();
                held_vld = 1'b0;
            end else begin
                hist.push_back(sif.src_ready);
                if (hist.size() > RL) void'(hist.pop_front());
                if (RL > 0 && sif.src_valid) chk(RL, "valid_needs_delayed_ready", 64'(dly), 64'(1));
                if (held_vld) begin
                    chk(RL, "hold_stable", 64'({sif.src_valid, cur}), 64'({1'b1, held}));
                    held_vld = 1'b0;
                end
                if (sif.src_valid && !dly) begin
                    held_vld = 1'b1;
                    held     = cur;
                end
                if (sif.src_valid && dly) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rl%0d extra_beat: got 0x%0h, want no beat", RL, cur);
                    end else begin
                        want = exp_q.pop_front();
                        chk(RL, "beat", 64'(cur), 64'(want.b));
                        if (want.gap) chk(RL, "b2b_gap", 64'(cyc - last_eop_cyc), 64'(2));
                        if (want.b.eop) begin
                            last_eop_cyc = cyc;
                            pkt_due      = cyc + 1;
                        end
                    end
                end
                if (pkt_done || cyc == pkt_due) chk(RL, "pkt_done", 64'(pkt_done), 64'(cyc == pkt_due));
                if (len_err || cyc == len_err_due) chk(RL, "len_err", 64'(len_err), 64'(cyc == len_err_due));
            end
        end

        initial begin : p_stim
            rst       = 1'b1;
            cmd_valid = 1'b0;
            cmd_len   = '0;
            cmd_seed  = '0;
            rnd_rdy   = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk(RL, "rst_cmd_ready", 64'(cmd_ready), 64'(1));
            chk(RL, "rst_valid", 64'(sif.src_valid), 64'(0));
            chk(RL, "rst_busy", 64'(busy), 64'(0));
            chk(RL, "rst_pulses", 64'({pkt_done, len_err}), 64'(0));
            chk(RL, "rst_beat", 64'({sif.src_data, sif.src_sop, sif.src_eop, sif.src_empty}), 64'(0));

            send_cmd(10, 'h10, 1'b0); wait_done();
            send_cmd(4, 'hFE, 1'b0);  wait_done();
            send_cmd(5, 'h20, 1'b0);
            send_cmd(3, 'h80, 1'b1);  wait_done();

            rdy_pat.delete();
            for (int i = 0; i < 12; i++) rdy_pat.push_back(i % 3 == 0);
            send_cmd(12, 'h33, 1'b0); wait_done();

            rdy_pat.delete();
            for (int i = 0; i < 5; i++) rdy_pat.push_back(i < 2);
            send_cmd(8, 'h5A, 1'b0);  wait_done();

            send_cmd(0, 'h00, 1'b0);
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                chk(RL, "zero_len_cmd_ready", 64'(cmd_ready), 64'(1));
                chk(RL, "zero_len_busy", 64'(busy), 64'(0));
            end

            send_cmd(12, 'h40, 1'b0);
            @(posedge clk); #1;
            rst = 1'b1;
            exp_q.delete();
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk(RL, "abort_valid", 64'(sif.src_valid), 64'(0));
            chk(RL, "abort_busy", 64'(busy), 64'(0));
            chk(RL, "abort_cmd_ready", 64'(cmd_ready), 64'(1));
            chk(RL, "abort_beat", 64'({sif.src_data, sif.src_sop, sif.src_eop, sif.src_empty}), 64'(0));
            send_cmd(4, 'h00, 1'b0);  wait_done();

            send_cmd(65535, 'h37, 1'b0); wait_done();

            rnd_rdy = 1'b1;
            for (int i = 0; i < 50; i++) begin
                int len;
                len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
                send_cmd(len, int'($urandom_range(0, 255)), 1'b0);
            end
            wait_done();
            rnd_rdy = 1'b0;
            wait_done();
            done = 1'b1;
        end
    end

    initial begin : p_end
        int n;
        n = 0;
        while (!(g_rl[0].done && g_rl[1].done) && n < 90000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 90000) begin
            total++;
            bad++;
            $display("FAIL run_timeout: stimulus unfinished after %0d cycles", n);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
